// File: rtl/fsm_serial_tx.sv
// Async-serial transmitter: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop bits. Every output is a flop; in_ready is decoded from flops only.
module fsm_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);
  localparam int BCW = $clog2(DATA_W + 1);
  localparam int BAW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BAW-1:0] BAUD_LAST = BAW'(BIT_CYCLES - 1);
  localparam logic [BCW-1:0] DBIT_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] SBIT_LAST = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, nstate;
  logic [BAW-1:0]    baud, nbaud;
  logic [BCW-1:0]    bit_cnt, nbit;
  logic [DATA_W-1:0] shift, nshift;
  logic              par;
  logic              accept, baud_last, nlast, ntxd;

  // done marks the last stop clock, so it doubles as the "ready again" flag.
  assign in_ready  = (state == IDLE) | done;
  assign accept    = in_valid & in_ready;
  assign baud_last = (baud == BAUD_LAST);

  always_comb begin
    nstate = state;
    nbaud  = baud;
    nbit   = bit_cnt;
    nshift = shift;
    unique case (state)
      IDLE: if (accept) begin
        nstate = START;
        nbaud  = '0;
        nbit   = '0;
        nshift = in_data;
      end
      START: if (baud_last) begin
        nstate = DATA;
        nbaud  = '0;
      end else nbaud = baud + 1'b1;
      DATA: if (baud_last) begin
        nbaud  = '0;
        nshift = shift >> 1;
        if (bit_cnt == DBIT_LAST) begin
          nbit   = '0;
          nstate = (PARITY_EN != 0) ? PARITY : STOP;
        end else nbit = bit_cnt + 1'b1;
      end else nbaud = baud + 1'b1;
      PARITY: if (baud_last) begin
        nstate = STOP;
        nbaud  = '0;
      end else nbaud = baud + 1'b1;
      STOP: if (baud_last) begin
        nbaud = '0;
        if (bit_cnt == SBIT_LAST) begin
          nbit = '0;
          if (accept) begin
            nstate = START;
            nshift = in_data;
          end else nstate = IDLE;
        end else nbit = bit_cnt + 1'b1;
      end else nbaud = baud + 1'b1;
      default: nstate = IDLE;
    endcase
    // Look ahead one clock so done lands exactly on the final stop-bit clock.
    nlast = (nstate == STOP) && (nbaud == BAUD_LAST) && (nbit == SBIT_LAST);
    unique case (nstate)
      START:   ntxd = 1'b0;
      DATA:    ntxd = nshift[0];
      PARITY:  ntxd = par;
      default: ntxd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nstate;
      baud    <= nbaud;
      bit_cnt <= nbit;
      shift   <= nshift;
      txd     <= ntxd;
      busy    <= (nstate != IDLE);
      done    <= nlast;
      if (accept) par <= (^in_data) ^ PARITY_ODD[0];
    end
  end
endmodule

// File: tb/tb_fsm_serial_tx.sv
// Directed bench: four transmitter variants share the input handshake; each test
// checks one variant's line bit-by-bit against a frame built from the sent word.
module tb_fsm_serial_tx;
  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic [3:0] rdy, txd, busy, done;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fsm_serial_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));
  fsm_serial_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pev (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));
  fsm_serial_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_pod (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]), .done(done[2]));
  fsm_serial_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_slow (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[3]), .txd(txd[3]), .busy(busy[3]), .done(done[3]));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy != 4'b0) && k < 200) begin
      tick();
      k++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Present a word while instance d is idle; returns after the accepting edge.
  task automatic send(input int d, input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
    chk("ready_idle", int'(rdy[d]), 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Walk the whole frame, scrambling in_data to prove it was captured.
  task automatic chk_frame(input int d, input logic [7:0] w, input int pe, input int po,
                           input int bc, input int sb);
    logic b [0:15];
    int n = 0;
    int len;
    b[n++] = 1'b0;
    for (int j = 0; j < 8; j++) b[n++] = w[j];
    if (pe != 0) b[n++] = (^w) ^ po[0];
    for (int j = 0; j < sb; j++) b[n++] = 1'b1;
    len = n * bc;
    for (int c = 0; c < len; c++) begin
      chk($sformatf("txd%0d_c%0d", d, c), int'(txd[d]), int'(b[c / bc]));
      chk($sformatf("done%0d_c%0d", d, c), int'(done[d]), int'(c == len - 1));
      chk($sformatf("rdy%0d_c%0d", d, c), int'(rdy[d]), int'(c == len - 1));
      chk($sformatf("busy%0d_c%0d", d, c), int'(busy[d]), 1);
      in_data = 8'($urandom);
      tick();
    end
    chk($sformatf("txd%0d_after", d), int'(txd[d]), 1);
    chk($sformatf("busy%0d_after", d), int'(busy[d]), 0);
    chk($sformatf("done%0d_after", d), int'(done[d]), 0);
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) tick();
    chk("rst_txd", int'(txd), 4'hF);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rdy", int'(rdy), 4'hF);
    resetn = 1'b1;
    tick();

    // single frame, defaults: 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5);
    chk_frame(0, 8'hA5, 0, 0, 1, 1);
    wait_idle();

    // parity even then odd on 0x07
    send(1, 8'h07);
    chk_frame(1, 8'h07, 1, 0, 1, 1);
    wait_idle();
    send(2, 8'h07);
    chk_frame(2, 8'h07, 1, 1, 1, 1);
    wait_idle();

    // 4 clocks per bit, 2 stop bits: 44-clock frame
    send(3, 8'h3C);
    chk_frame(3, 8'h3C, 0, 0, 4, 2);
    wait_idle();

    // back-to-back 0x00 then 0xFF with in_valid held
    in_data  = 8'h00;
    in_valid = 1'b1;
    chk("b2b_rdy0", int'(rdy[0]), 1);
    tick();
    in_data = 8'hFF;
    for (int i = 1; i <= 20; i++) begin
      automatic int pos = (i - 1) % 10;
      automatic int eb  = (pos == 0) ? 0 : (pos == 9) ? 1 : ((i > 10) ? 1 : 0);
      chk($sformatf("b2b_txd_%0d", i), int'(txd[0]), eb);
      chk($sformatf("b2b_done_%0d", i), int'(done[0]), int'(pos == 9));
      chk($sformatf("b2b_rdy_%0d", i), int'(rdy[0]), int'(pos == 9));
      tick();
      if (i == 10) in_valid = 1'b0;
    end
    chk("b2b_txd_end", int'(txd[0]), 1);
    wait_idle();

    // in_data changes while busy
    send(0, 8'h5A);
    chk_frame(0, 8'h5A, 0, 0, 1, 1);
    wait_idle();

    // reset during data bit 3 (clock index 4 after accept)
    send(0, 8'h96);
    repeat (4) begin
      in_data = 8'($urandom);
      tick();
    end
    chk("pre_rst_txd", int'(txd[0]), 0);
    chk("pre_rst_busy", int'(busy[0]), 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_txd", int'(txd[0]), 1);
    chk("midrst_busy", int'(busy[0]), 0);
    tick();
    chk("midrst_done", int'(done[0]), 0);
    chk("midrst_txd2", int'(txd[0]), 1);
    resetn = 1'b1;
    tick();
    chk("postrst_done", int'(done[0]), 0);
    send(0, 8'h3C);
    chk_frame(0, 8'h3C, 0, 0, 1, 1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
    $fatal(1, "timeout");
  end
endmodule
